// File: rtl/spi_master_ng.sv
// spi_master_ng: SPI master with an Avalon-MM slave register interface.
// Words written to DATA are queued in a TX FIFO and shifted out on mosi. Received words are
// queued in an RX FIFO and read back through DATA. Frame length, bit order, CPOL/CPHA,
// chip-select control and loopback are set in CONTROL. The SCLK half-period is set in DIV.
//
// Ports:
//   clk, reset            - clock and asynchronous active-low reset
//   chipselect/read/write - Avalon-MM strobes (zero-wait-state reads)
//   address[1:0]          - 0 DATA, 1 STATUS, 2 CONTROL, 3 DIV
//   byteenable[3:0]       - ignored, all writes are full-word
//   writedata/readdata    - Avalon data (readdata is combinational)
//   sclk, mosi, miso      - SPI bus
//   cs_n[NUM_CS-1:0]      - active-low chip selects
module spi_master_ng #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int NUM_CS     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [1:0]        address,
    input  logic [3:0]        byteenable,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int BW    = $clog2(DATA_W);

    typedef enum logic [2:0] {StIdle, StSetup, StXfer, StHold, StGap} state_e;

    state_e state_q, state_d;

    // Software-visible registers
    logic [15:0] ctrl_q, div_q;
    logic        txo_q, txo_d, rxo_q, rxo_d;

    // FIFOs
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic              tx_empty, tx_full, rx_empty, rx_full;

    // Frame configuration captured at frame start
    logic [15:0] div_l_q;
    logic [5:0]  flen_q;
    logic        lsb_q, cpol_q, cpha_q, cs_auto_q, cs_force_q, loop_q;
    logic [2:0]  cs_sel_q;

    // Shift engine
    logic [15:0]       cnt_q, cnt_d;
    logic [6:0]        edge_q;
    logic              sclk_q;
    logic [DATA_W-1:0] sh_tx_q, sh_rx_q;

    // Decoded strobes and helpers
    logic        reg_wr, reg_rd;
    logic        tx_push_req, tx_push, tx_pop;
    logic        rx_push, rx_do_push, rx_pop;
    logic        half_end, frame_start, burst, edge_now, sample_now;
    logic [5:0]  flen_live;
    logic [6:0]  last_edge;
    logic [6:0]  bidx;
    logic [5:0]  pos;
    logic [BW-1:0] pos_b;
    logic        mosi_bit, miso_int;
    logic        cs_on;
    logic [2:0]  cs_sel_w;
    logic        unused_bits;

    assign unused_bits = ^{byteenable, writedata, pos};

    // ------------------------------------------------------------------
    // Bus decode and FIFO status
    // ------------------------------------------------------------------
    assign reg_wr = chipselect && write;
    assign reg_rd = chipselect && read;

    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign rx_empty = (rx_wp_q == rx_rp_q);
    assign tx_full  = (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]) && (tx_wp_q[AW] != tx_rp_q[AW]);
    assign rx_full  = (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]) && (rx_wp_q[AW] != rx_rp_q[AW]);

    assign flen_live = (ctrl_q[5:0] >= 6'(DATA_W)) ? 6'(DATA_W - 1) : ctrl_q[5:0];

    assign half_end    = (cnt_q == div_l_q);
    assign frame_start = (state_q == StIdle) && ctrl_q[7] && !tx_empty;
    assign burst       = (state_q == StHold) && half_end && ctrl_q[7] && !tx_empty;
    // 2*(flen+1) edges; the last one coincides with the XFER -> HOLD transition
    assign last_edge   = {flen_q, 1'b0} + 7'd1;
    assign edge_now    = (state_q == StXfer) && half_end;
    // CPHA=0 samples on even (leading) edges, CPHA=1 on odd (trailing) edges
    assign sample_now  = edge_now && (edge_q[0] == cpha_q);

    assign tx_push_req = reg_wr && (address == 2'd0);
    assign tx_pop      = frame_start || burst;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);

    assign rx_push     = (state_q == StHold) && half_end;
    assign rx_pop      = reg_rd && (address == 2'd0) && !rx_empty;
    assign rx_do_push  = rx_push && (!rx_full || rx_pop);

    assign cnt_d = ((state_q == StIdle) || half_end) ? 16'd0 : cnt_q + 16'd1;

    // Bit index on the wire: CPHA=0 advances after each trailing edge, CPHA=1 after each
    // leading edge except the first, which only launches bit 0 already on mosi.
    always_comb begin
        if (!cpha_q) begin
            bidx = edge_q >> 1;
        end else if (edge_q == 7'd0) begin
            bidx = 7'd0;
        end else begin
            bidx = (edge_q - 7'd1) >> 1;
        end
        if (bidx > {1'b0, flen_q}) begin
            bidx = {1'b0, flen_q};
        end
        pos = lsb_q ? bidx[5:0] : (flen_q - bidx[5:0]);
    end

    assign pos_b    = pos[BW-1:0];
    assign mosi_bit = sh_tx_q[pos_b];
    assign miso_int = loop_q ? mosi_bit : miso;

    always_comb begin
        txo_d = txo_q;
        if (reg_wr && (address == 2'd1) && writedata[5]) begin
            txo_d = 1'b0;
        end
        if (tx_push_req && tx_full && !tx_pop) begin
            txo_d = 1'b1;
        end
    end

    always_comb begin
        rxo_d = rxo_q;
        if (reg_wr && (address == 2'd1) && writedata[2]) begin
            rxo_d = 1'b0;
        end
        if (rx_push && rx_full && !rx_pop) begin
            rxo_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        readdata = 32'd0;
        if (reg_rd) begin
            unique case (address)
                2'd0: begin
                    if (!rx_empty) begin
                        readdata = 32'(rx_mem[rx_rp_q[AW-1:0]]);
                    end
                end
                2'd1: readdata = {25'd0, (state_q != StIdle), txo_q, tx_full, tx_empty,
                                  rxo_q, rx_full, rx_empty};
                2'd2: readdata = {16'd0, ctrl_q};
                default: readdata = {16'd0, div_q};
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (frame_start) state_d = StSetup;
            StSetup: if (half_end) state_d = StXfer;
            StXfer:  if (half_end && (edge_q == last_edge)) state_d = StHold;
            StHold: begin
                if (half_end) begin
                    state_d = burst ? StXfer : StGap;
                end
            end
            StGap:   if (half_end) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        sclk = (state_q == StIdle) ? ctrl_q[8] : sclk_q;
        mosi = 1'b0;
        if ((state_q == StSetup) || (state_q == StXfer) || (state_q == StHold)) begin
            mosi = mosi_bit;
        end
        // In IDLE the live CONTROL drives cs_force; during a frame the captured copy does
        if (state_q == StIdle) begin
            cs_on    = !ctrl_q[10] && ctrl_q[14];
            cs_sel_w = ctrl_q[13:11];
        end else begin
            cs_on    = cs_auto_q ? (state_q != StGap) : cs_force_q;
            cs_sel_w = cs_sel_q;
        end
        cs_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_on && (cs_sel_w == 3'(i))) begin
                cs_n[i] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers, FIFO pointers and shift engine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q     <= '0;
            div_q      <= '0;
            txo_q      <= 1'b0;
            rxo_q      <= 1'b0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            div_l_q    <= '0;
            flen_q     <= '0;
            lsb_q      <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            cs_auto_q  <= 1'b0;
            cs_force_q <= 1'b0;
            loop_q     <= 1'b0;
            cs_sel_q   <= '0;
            cnt_q      <= '0;
            edge_q     <= '0;
            sclk_q     <= 1'b0;
            sh_tx_q    <= '0;
            sh_rx_q    <= '0;
        end else begin
            if (reg_wr && (address == 2'd2)) ctrl_q <= writedata[15:0];
            if (reg_wr && (address == 2'd3)) div_q <= writedata[15:0];
            txo_q <= txo_d;
            rxo_q <= rxo_d;

            if (tx_push)    tx_wp_q <= tx_wp_q + PTR_W'(1);
            if (tx_pop)     tx_rp_q <= tx_rp_q + PTR_W'(1);
            if (rx_do_push) rx_wp_q <= rx_wp_q + PTR_W'(1);
            if (rx_pop)     rx_rp_q <= rx_rp_q + PTR_W'(1);

            cnt_q <= cnt_d;

            if (frame_start) begin
                div_l_q    <= div_q;
                cpol_q     <= ctrl_q[8];
                cpha_q     <= ctrl_q[9];
                cs_auto_q  <= ctrl_q[10];
                cs_sel_q   <= ctrl_q[13:11];
                cs_force_q <= ctrl_q[14];
                loop_q     <= ctrl_q[15];
                sclk_q     <= ctrl_q[8];
            end

            // Burst continuation re-captures only the word format; bus timing and chip
            // select stay as they were for the whole burst.
            if (frame_start || burst) begin
                sh_tx_q <= tx_mem[tx_rp_q[AW-1:0]];
                sh_rx_q <= '0;
                edge_q  <= '0;
                flen_q  <= flen_live;
                lsb_q   <= ctrl_q[6];
            end else if (edge_now) begin
                edge_q <= edge_q + 7'd1;
                sclk_q <= ~sclk_q;
                if (sample_now) begin
                    sh_rx_q[pos_b] <= miso_int;
                end
            end
        end
    end

    // FIFO storage needs no reset: occupancy is defined by the pointers alone
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wp_q[AW-1:0]] <= writedata[DATA_W-1:0];
        end
        if (rx_do_push) begin
            rx_mem[rx_wp_q[AW-1:0]] <= sh_rx_q;
        end
    end

endmodule
